// File: rtl/rfphoenix_ptg_writer.sv
// Page-table-group insert engine: scans a 16-lane PTE group and writes one translation.
// RFPHOENIX_PTG_PARALLEL_SCAN_EN selects a single-cycle scan instead of one entry per cycle.
module rfphoenix_ptg_writer #(
    parameter int NENTRIES = 8,
    parameter int LANEW    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [15:0]                 req_tag,
    input  logic [9:0]                  req_asid,
    input  logic                        req_g,
    input  logic [31:0]                 req_ppn,
    input  logic [2*NENTRIES*LANEW-1:0] grp_i,
    output logic                        done_valid,
    input  logic                        done_ready,
    output logic [2*NENTRIES*LANEW-1:0] grp_o,
    output logic [2:0]                  slot_o,
    output logic                        hit_o,
    output logic                        evict_o
);

    localparam int GW = 2 * NENTRIES * LANEW;
    localparam int IW = 3;

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

    state_t state, state_nx;

    logic [GW-1:0]       grp_q;
    logic [GW-1:0]       grp_w;
    logic [15:0]         tag_q;
    logic [9:0]          asid_q;
    logic                g_q;
    logic [31:0]         ppn_q;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       rr;
    logic [IW-1:0]       hit_idx;
    logic [IW-1:0]       inv_idx;
    logic [IW-1:0]       sel;
    logic                hit_f;
    logic                inv_f;
    logic [IW-1:0]       slot_q;
    logic                hit_q;
    logic                evict_q;
    logic                accept;
    logic                do_evict;
    logic [NENTRIES-1:0] ent_valid;
    logic [NENTRIES-1:0] ent_match;
    logic                scan_hit;
    logic                scan_inv;
    logic [IW-1:0]       scan_hit_idx;
    logic [IW-1:0]       scan_inv_idx;
    logic                scan_last;

    assign accept = req_valid && req_ready;

    // Per-entry valid/match decode of the captured tag words
    always_comb begin
        ent_valid = '0;
        ent_match = '0;
        for (int n = 0; n < NENTRIES; n++) begin
            ent_valid[n] = grp_q[(2*n+1)*LANEW + 20];
            ent_match[n] = ent_valid[n]
                && (grp_q[(2*n+1)*LANEW +: 16] == tag_q)
                && ((grp_q[(2*n+1)*LANEW + 22 +: 10] == asid_q)
                    || grp_q[(2*n+1)*LANEW + 21] || g_q);
        end
    end

`ifdef RFPHOENIX_PTG_PARALLEL_SCAN_EN
    logic [IW-1:0] p_hit_idx;
    logic [IW-1:0] p_inv_idx;

    always_comb begin
        p_hit_idx = '0;
        p_inv_idx = '0;
        for (int n = NENTRIES - 1; n >= 0; n--) begin
            if (ent_match[n]) p_hit_idx = IW'(n);
            if (!ent_valid[n]) p_inv_idx = IW'(n);
        end
        scan_hit     = |ent_match;
        scan_hit_idx = p_hit_idx;
        scan_inv     = ~&ent_valid;
        scan_inv_idx = p_inv_idx;
        scan_last    = 1'b1;
    end
`else
    always_comb begin
        scan_hit     = ent_match[idx];
        scan_hit_idx = idx;
        scan_inv     = !ent_valid[idx];
        scan_inv_idx = idx;
        scan_last    = (idx == IW'(NENTRIES - 1));
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = SCAN;
            SCAN:    if (scan_last) state_nx = WRITE;
            WRITE:   state_nx = DONE;
            DONE:    if (done_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Slot priority: existing match, then first hole, then round-robin victim
    always_comb begin
        req_ready  = (state == IDLE);
        done_valid = (state == DONE);
        do_evict   = !hit_f && !inv_f;
        sel        = hit_f ? hit_idx : (inv_f ? inv_idx : rr);
        grp_w      = grp_q;
        for (int n = 0; n < NENTRIES; n++) begin
            if (IW'(n) == sel) begin
                grp_w[(2*n)*LANEW +: LANEW]   = ppn_q;
                grp_w[(2*n+1)*LANEW +: LANEW] = {asid_q, g_q, 1'b1, 4'b0, tag_q};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_q   <= '0;
            tag_q   <= '0;
            asid_q  <= '0;
            g_q     <= 1'b0;
            ppn_q   <= '0;
            idx     <= '0;
            rr      <= '0;
            hit_idx <= '0;
            inv_idx <= '0;
            hit_f   <= 1'b0;
            inv_f   <= 1'b0;
            slot_q  <= '0;
            hit_q   <= 1'b0;
            evict_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        grp_q   <= grp_i;
                        tag_q   <= req_tag;
                        asid_q  <= req_asid;
                        g_q     <= req_g;
                        ppn_q   <= req_ppn;
                        idx     <= '0;
                        hit_f   <= 1'b0;
                        inv_f   <= 1'b0;
                        hit_idx <= '0;
                        inv_idx <= '0;
                    end
                end
                SCAN: begin
                    idx <= idx + 1'b1;
                    if (scan_hit && !hit_f) begin
                        hit_f   <= 1'b1;
                        hit_idx <= scan_hit_idx;
                    end
                    if (scan_inv && !inv_f) begin
                        inv_f   <= 1'b1;
                        inv_idx <= scan_inv_idx;
                    end
                end
                WRITE: begin
                    grp_q   <= grp_w;
                    slot_q  <= sel;
                    hit_q   <= hit_f;
                    evict_q <= do_evict;
                    if (do_evict) rr <= rr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign grp_o   = grp_q;
    assign slot_o  = slot_q;
    assign hit_o   = hit_q;
    assign evict_o = evict_q;

endmodule
